// File: rtl/fp32_to_int32.sv
`default_nettype none
// fp32_to_int32: multi-cycle IEEE-754 single to int32 converter, round half away from zero.
// Define FP2INT_SAT_EN to saturate overflow/Inf; otherwise overflow wraps and Inf gives 0.
module fp32_to_int32 #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        out_inexact,
  output logic        out_nan
);

`ifdef FP2INT_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif
  localparam logic [31:0] NEG_2P31 = 32'hCF00_0000;

  typedef enum logic [2:0] {IDLE, DECODE, SHIFT, ROUND, OUT} state_t;

  state_t      state, state_n;
  logic [31:0] op, op_n;
  logic [55:0] mag, mag_n;
  logic [4:0]  rem, rem_n;
  logic        left, left_n;
  logic        guard, guard_n;
  logic        sticky, sticky_n;
  logic [31:0] data_n;
  logic        ovf_n, inexact_n, nan_n;

  logic              sign;
  logic [7:0]        expo;
  logic [22:0]       frac;
  logic [23:0]       mant;
  logic signed [9:0] e;
  logic signed [9:0] esh;
  logic [4:0]        esh_abs;
  logic [55:0]       wide_ovf;
  logic [31:0]       sat_val;
  logic [31:0]       rounded;
  logic [31:0]       signed_res;

  assign sign    = op[31];
  assign expo    = op[30:23];
  assign frac    = op[22:0];
  assign mant    = {(expo != 8'd0), frac};
  assign e       = $signed({2'b00, expo}) - 10'sd127;
  assign esh     = e - 10'sd23;
  assign esh_abs = esh[9] ? 5'(-esh) : 5'(esh);
  // Overflowing values are already integers; only their low 32 bits survive a wrap.
  assign wide_ovf = (esh >= 10'sd32) ? 56'd0 : ({32'd0, mant} << esh[4:0]);
  assign sat_val  = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;

  assign rounded    = mag[31:0] + {31'd0, guard};
  assign signed_res = sign ? (32'd0 - rounded) : rounded;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  always_comb begin
    state_n   = state;
    op_n      = op;
    mag_n     = mag;
    rem_n     = rem;
    left_n    = left;
    guard_n   = guard;
    sticky_n  = sticky;
    data_n    = out_data;
    ovf_n     = out_ovf;
    inexact_n = out_inexact;
    nan_n     = out_nan;
    case (state)
      IDLE: begin
        if (in_valid) begin
          op_n    = in_data;
          state_n = DECODE;
        end
      end
      DECODE: begin
        ovf_n     = 1'b0;
        nan_n     = 1'b0;
        inexact_n = 1'b0;
        guard_n   = 1'b0;
        sticky_n  = 1'b0;
        if (expo == 8'hFF) begin
          if (frac != 23'd0) begin
            nan_n  = 1'b1;
            data_n = 32'd0;
          end else begin
            ovf_n  = 1'b1;
            data_n = SAT ? sat_val : 32'd0;
          end
          state_n = OUT;
        end else if (e >= 10'sd31 && op != NEG_2P31) begin
          ovf_n   = 1'b1;
          mag_n   = wide_ovf;
          state_n = ROUND;
        end else if (e < -10'sd1) begin
          mag_n    = 56'd0;
          sticky_n = (mant != 24'd0);
          state_n  = ROUND;
        end else begin
          mag_n   = {32'd0, mant};
          left_n  = (e >= 10'sd23);
          rem_n   = esh_abs;
          state_n = (esh_abs == 5'd0) ? ROUND : SHIFT;
        end
      end
      SHIFT: begin
        // Up to SHIFT_STEP single-bit moves; right moves feed guard, older guard folds into sticky.
        for (int i = 0; i < SHIFT_STEP; i++) begin
          if (rem_n != 5'd0) begin
            if (left) begin
              mag_n = mag_n << 1;
            end else begin
              sticky_n = sticky_n | guard_n;
              guard_n  = mag_n[0];
              mag_n    = mag_n >> 1;
            end
            rem_n = rem_n - 5'd1;
          end
        end
        if (rem_n == 5'd0) state_n = ROUND;
      end
      ROUND: begin
        inexact_n = guard | sticky;
        data_n    = (out_ovf && SAT) ? sat_val : signed_res;
        state_n   = OUT;
      end
      OUT: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op          <= 32'd0;
      mag         <= 56'd0;
      rem         <= 5'd0;
      left        <= 1'b0;
      guard       <= 1'b0;
      sticky      <= 1'b0;
      out_data    <= 32'd0;
      out_ovf     <= 1'b0;
      out_inexact <= 1'b0;
      out_nan     <= 1'b0;
    end else begin
      state       <= state_n;
      op          <= op_n;
      mag         <= mag_n;
      rem         <= rem_n;
      left        <= left_n;
      guard       <= guard_n;
      sticky      <= sticky_n;
      out_data    <= data_n;
      out_ovf     <= ovf_n;
      out_inexact <= inexact_n;
      out_nan     <= nan_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp32_to_int32.sv
`default_nettype none
// tb_fp32_to_int32: directed and random conversions checked against a real-arithmetic model.
module tb_fp32_to_int32;
  localparam int STEP = 4;
`ifdef FP2INT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_inexact;
  logic        out_nan;

  int          compared = 0;
  int          mismatched = 0;
  int          last_lat;
  logic [31:0] last_data;

  fp32_to_int32 #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_inexact(out_inexact), .out_nan(out_nan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Value-level model: decode to a real, round half away from zero, reduce mod 2^32 on overflow.
  // Latency counts edges from the accept edge through the edge that raises out_valid.
  function automatic void model(input logic [31:0] x, output logic [31:0] d,
                                output logic ovf, output logic inx, output logic nan,
                                output int lat);
    bit    s;
    int    ex;
    int    fr;
    int    sh;
    real   mag;
    real   low;
    longint u;
    s   = x[31];
    ex  = int'(x[30:23]);
    fr  = int'(x[22:0]);
    ovf = 1'b0; inx = 1'b0; nan = 1'b0; d = 32'd0;
    if (ex == 255) begin
      lat = 2;
      if (fr != 0) nan = 1'b1;
      else begin
        ovf = 1'b1;
        d   = SAT ? (s ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'd0;
      end
      return;
    end
    if (ex == 0) mag = $itor(fr) * (2.0 ** (-149));
    else         mag = $itor(fr + 8388608) * (2.0 ** (ex - 150));
    if (mag >= 2147483648.0 && !(s && mag == 2147483648.0)) begin
      ovf = 1'b1;
      low = mag - $floor(mag / 4294967296.0) * 4294967296.0;
      u   = longint'(low);
      d   = SAT ? (s ? 32'h8000_0000 : 32'h7FFF_FFFF) : (s ? 32'(-u) : 32'(u));
      lat = 3;
    end else begin
      u   = longint'($floor(mag + 0.5));
      inx = (mag != $floor(mag));
      d   = s ? 32'(-u) : 32'(u);
      if (ex - 127 < -1) lat = 3;
      else begin
        sh  = (ex - 127 >= 23) ? (ex - 150) : (150 - ex);
        lat = 3 + (sh + STEP - 1) / STEP;
      end
    end
  endfunction

  task automatic run(input logic [31:0] x, input int hold);
    logic [31:0] ed;
    logic [31:0] held;
    logic        eo, ei, en;
    int          el;
    int          n;
    model(x, ed, eo, ei, en, el);
    in_data  = x;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    last_lat = 1;
    while (out_valid !== 1'b1 && last_lat < 100) begin
      @(posedge clk); #1; last_lat++;
    end
    last_data = out_data;
    check($sformatf("lat %h", x), 32'(last_lat), 32'(el));
    check($sformatf("data %h", x), out_data, ed);
    check($sformatf("ovf %h", x), 32'(out_ovf), 32'(eo));
    check($sformatf("inexact %h", x), 32'(out_inexact), 32'(ei));
    check($sformatf("nan %h", x), 32'(out_nan), 32'(en));
    check($sformatf("busy %h", x), 32'(in_ready), 32'd0);
    held = out_data;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h3F80_0000;
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, held);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_valid", 32'(out_valid), 32'd0);
    check("hs_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] x;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_flags", {29'd0, out_ovf, out_inexact, out_nan}, 32'd0);

    run(32'h400B851F, 0);
    check("p218_lat9", 32'(last_lat), 32'd9);
    check("p218_data", last_data, 32'd2);
    run(32'h511502F9, 0);
    run(32'hC0200000, 0);
    check("m2p5_data", last_data, 32'hFFFF_FFFD);
    run(32'h3F000000, 0);
    run(32'hCF000000, 0);
    check("min_int", last_data, 32'h8000_0000);
    run(32'h7FC00000, 0);
    run(32'hFF800000, 0);
    run(32'h7F800000, 0);
    run(32'h00000001, 0);
    run(32'h3EFFFFFF, 0);
    run(32'h4F000000, 0);
    run(32'hCF000001, 0);
    run(32'h00000000, 0);
    run(32'h80000000, 0);
    run(32'h4B7FFFFF, 0);
    run(32'hBFC00000, 5);

    // Reset while the 2.18 conversion is shifting; out_data still holds -1.5's result.
    run(32'hBFC00000, 0);
    in_data = 32'h400B851F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_flags", {29'd0, out_ovf, out_inexact, out_nan}, 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(32'h400B851F, 0);

    for (int i = 0; i < 150; i++) begin
      x = $urandom;
      if (i % 2 == 0) x[30:23] = 8'($urandom_range(170, 110));
      run(x, int'($urandom_range(2, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
